// File: rtl/dac_bus_writer.sv
// Drives the dual-channel 8-bit parallel DAC: A write, B write, LDAC pulse; also clear and power-down.
// Latency: 2*(SETUP_CYC+WR_CYC+HOLD_CYC)+WR_CYC busy cycles per pair; ready returns one cycle later.
// Backpressure: sample_ready is low while a sequence or clear runs, while a clear is pending, or while pd_req is high.
module dac_bus_writer #(
    parameter int SETUP_CYC = 2,
    parameter int WR_CYC    = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] sample_a,
    input  logic [7:0] sample_b,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       pd_req,
    input  logic       clr_req,
    output logic       busy,
    output logic [7:0] DB,
    output logic       CS,
    output logic       WR,
    output logic       AB,
    output logic       PD,
    output logic       LDAC,
    output logic       CLR
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 255 || WR_CYC < 1 || WR_CYC > 255 ||
            HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_param
            $error("dac_bus_writer: SETUP_CYC, WR_CYC and HOLD_CYC must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] WR_LD    = 8'(WR_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, SET_A, STB_A, HLD_A, SET_B, STB_B, HLD_B, LOAD, CLEAR
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] b_reg, b_n;
    logic       clr_pending, clr_pend_n;
    logic [7:0] db_n;
    logic       ab_n, cs_n, wr_n, ldac_n, clr_o_n, rdy_n, busy_n;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        b_n        = b_reg;
        db_n       = DB;
        ab_n       = AB;
        clr_pend_n = clr_pending | clr_req;

        case (state)
            IDLE: begin
                // A clear request arriving this cycle already beats a sample offered alongside it.
                if (clr_pending | clr_req) begin
                    state_n    = CLEAR;
                    cnt_n      = WR_LD;
                    clr_pend_n = 1'b0;
                end else if (sample_valid & sample_ready & ~pd_req) begin
                    state_n = SET_A;
                    cnt_n   = SETUP_LD;
                    db_n    = sample_a;
                    ab_n    = 1'b0;
                    b_n     = sample_b;
                end
            end
            default: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    case (state)
                        SET_A: begin state_n = STB_A; cnt_n = WR_LD;   end
                        STB_A: begin state_n = HLD_A; cnt_n = HOLD_LD; end
                        HLD_A: begin
                            state_n = SET_B;
                            cnt_n   = SETUP_LD;
                            db_n    = b_reg;
                            ab_n    = 1'b1;
                        end
                        SET_B: begin state_n = STB_B; cnt_n = WR_LD;   end
                        STB_B: begin state_n = HLD_B; cnt_n = HOLD_LD; end
                        HLD_B: begin state_n = LOAD;  cnt_n = WR_LD;   end
                        default: begin state_n = IDLE; cnt_n = 8'd0;  end
                    endcase
                end
            end
        endcase

        // Pins are decoded from the next state so every output comes straight from a flop.
        cs_n    = !(state_n inside {SET_A, STB_A, HLD_A, SET_B, STB_B, HLD_B});
        wr_n    = !(state_n inside {STB_A, STB_B});
        ldac_n  = (state_n != LOAD);
        clr_o_n = (state_n != CLEAR);
        rdy_n   = (state_n == IDLE) & ~clr_pend_n & ~pd_req;
        busy_n  = (state_n != IDLE) | clr_pend_n;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            b_reg        <= 8'd0;
            clr_pending  <= 1'b0;
            DB           <= 8'h00;
            AB           <= 1'b0;
            CS           <= 1'b1;
            WR           <= 1'b1;
            PD           <= 1'b1;
            LDAC         <= 1'b1;
            CLR          <= 1'b1;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            b_reg        <= b_n;
            clr_pending  <= clr_pend_n;
            DB           <= db_n;
            AB           <= ab_n;
            CS           <= cs_n;
            WR           <= wr_n;
            PD           <= ~pd_req;
            LDAC         <= ldac_n;
            CLR          <= clr_o_n;
            sample_ready <= rdy_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_dac_bus_writer.sv
// Directed bench for dac_bus_writer: pin sequencing, back-to-back pairs, clear, power-down, reset.
module tb_dac_bus_writer;

    logic       Clk, Rst;
    logic [7:0] sample_a, sample_b;
    logic       sample_valid, sample_ready, pd_req, clr_req, busy;
    logic [7:0] DB;
    logic       CS, WR, AB, PD, LDAC, CLR;

    int checks = 0;
    int errors = 0;

    int         cs_lo, wr_lo, ldac_lo, clr_lo, ldac_cs_bad, ldac_at_clr;
    logic       wr_q;
    logic [8:0] wq[$];

    dac_bus_writer dut (
        .Clk(Clk), .Rst(Rst),
        .sample_a(sample_a), .sample_b(sample_b),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .pd_req(pd_req), .clr_req(clr_req), .busy(busy),
        .DB(DB), .CS(CS), .WR(WR), .AB(AB), .PD(PD), .LDAC(LDAC), .CLR(CLR)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        cs_lo = 0; wr_lo = 0; ldac_lo = 0; clr_lo = 0; ldac_cs_bad = 0; ldac_at_clr = 99;
        wr_q = 1'b1;
        wq.delete();
    endtask

    // Advance to the next falling edge and record what the pins did in the cycle just entered.
    task automatic step();
        @(negedge Clk);
        if (!CS) cs_lo++;
        if (!WR) wr_lo++;
        if (!LDAC) begin
            ldac_lo++;
            if (!CS) ldac_cs_bad++;
        end
        if (!CLR) begin
            if (clr_lo == 0) ldac_at_clr = ldac_lo;
            clr_lo++;
        end
        if (wr_q == 1'b0 && WR == 1'b1) wq.push_back({AB, DB});
        wr_q = WR;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!sample_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("ready_timeout", 32'(sample_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, output int lat);
        int n;
        sample_a = a;
        sample_b = b;
        sample_valid = 1'b1;
        wait_ready(n);
        step();
        sample_valid = 1'b0;
        wait_ready(n);
        lat = n + 1;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [8:0] exp);
        if (idx < wq.size()) check(tag, 32'(wq[idx]), 32'(exp));
        else check(tag, 32'h1ff, 32'(exp));
    endtask

    initial begin
        int lat, n, last, t, i, bad;
        logic [8:0] e;

        Rst = 1'b0; sample_a = 8'h00; sample_b = 8'h00;
        sample_valid = 1'b0; pd_req = 1'b0; clr_req = 1'b0;
        clr_stats();
        step(); step();

        check("rst_db", 32'(DB), 32'h00);
        check("rst_cs", 32'(CS), 32'd1);
        check("rst_wr", 32'(WR), 32'd1);
        check("rst_ab", 32'(AB), 32'd0);
        check("rst_pd", 32'(PD), 32'd1);
        check("rst_ldac", 32'(LDAC), 32'd1);
        check("rst_clr", 32'(CLR), 32'd1);
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        Rst = 1'b1;
        step();
        check("post_rst_ready", 32'(sample_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single pair with default timing
        clr_stats();
        send(8'h5A, 8'hC3, lat);
        check("t1_latency", 32'(lat), 32'd18);
        check("t1_cs_low", 32'(cs_lo), 32'd14);
        check("t1_wr_low", 32'(wr_lo), 32'd6);
        check("t1_ldac_low", 32'(ldac_lo), 32'd3);
        check("t1_ldac_cs", 32'(ldac_cs_bad), 32'd0);
        check("t1_nwrites", 32'(wq.size()), 32'd2);
        check_write("t1_write_a", 0, {1'b0, 8'h5A});
        check_write("t1_write_b", 1, {1'b1, 8'hC3});

        // Back-to-back pairs with sample_valid held high
        clr_stats();
        i = 0; last = -1; t = 0;
        sample_a = 8'h00; sample_b = 8'h80; sample_valid = 1'b1;
        for (int c = 0; c < 200 && i < 3; c++) begin
            if (sample_ready) begin
                if (last >= 0) check("b2b_gap", 32'(t - last), 32'd18);
                last = t;
                i++;
                step(); t++;
                if (i < 3) begin
                    sample_a = 8'(i);
                    sample_b = 8'(8'h80 + i);
                end else begin
                    sample_valid = 1'b0;
                end
            end else begin
                step(); t++;
            end
        end
        check("b2b_accepted", 32'(i), 32'd3);
        wait_ready(n);
        check("b2b_nwrites", 32'(wq.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) e = {1'b0, 8'(k / 2)};
            else e = {1'b1, 8'(8'h80 + k / 2)};
            check_write("b2b_write", k, e);
        end

        // Clear requested during STB_A; a new pair is offered straight away
        clr_stats();
        sample_a = 8'h11; sample_b = 8'h22; sample_valid = 1'b1;
        wait_ready(n);
        step();
        sample_valid = 1'b0;
        step(); step();
        check("t3_in_stb_a", 32'(WR), 32'd0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        sample_a = 8'h33; sample_b = 8'h44; sample_valid = 1'b1;
        bad = 0; n = 0;
        while (!sample_ready && n < 300) begin
            step(); n++;
            if (!sample_ready && !busy) bad++;
        end
        check("t3_busy_gap", 32'(bad), 32'd0);
        check("t3_clr_low", 32'(clr_lo), 32'd3);
        check("t3_ldac_before_clr", 32'(ldac_at_clr), 32'd3);
        check("t3_nwrites_before", 32'(wq.size()), 32'd2);
        check_write("t3_write_a", 0, {1'b0, 8'h11});
        check_write("t3_write_b", 1, {1'b1, 8'h22});
        step();
        sample_valid = 1'b0;
        wait_ready(n);
        check("t3_nwrites_after", 32'(wq.size()), 32'd4);
        check_write("t3_next_a", 2, {1'b0, 8'h33});
        check_write("t3_next_b", 3, {1'b1, 8'h44});

        // Clear and valid sample in the same IDLE cycle
        clr_stats();
        sample_a = 8'h66; sample_b = 8'h77; sample_valid = 1'b1; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("t4_clr_first", 32'(CLR), 32'd0);
        check("t4_cs_high", 32'(CS), 32'd1);
        check("t4_ready_low", 32'(sample_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        wait_ready(n);
        check("t4_clear_len", 32'(n), 32'd3);
        step();
        sample_valid = 1'b0;
        wait_ready(n);
        check("t4_clr_low", 32'(clr_lo), 32'd3);
        check("t4_nwrites", 32'(wq.size()), 32'd2);
        check_write("t4_write_a", 0, {1'b0, 8'h66});
        check_write("t4_write_b", 1, {1'b1, 8'h77});

        // Power-down raised during SET_B
        clr_stats();
        sample_a = 8'h55; sample_b = 8'h99; sample_valid = 1'b1;
        wait_ready(n);
        step();
        sample_valid = 1'b0;
        repeat (7) step();
        check("t5_in_set_b", 32'({CS, WR, AB}), 32'b011);
        pd_req = 1'b1;
        sample_valid = 1'b1;
        step();
        check("t5_pd_low", 32'(PD), 32'd0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sample_ready) bad++;
        end
        check("t5_ready_held", 32'(bad), 32'd0);
        check("t5_done", 32'(busy), 32'd0);
        check("t5_nwrites", 32'(wq.size()), 32'd2);
        check("t5_ldac_low", 32'(ldac_lo), 32'd3);
        sample_valid = 1'b0;
        pd_req = 1'b0;
        step();
        check("t5_pd_high", 32'(PD), 32'd1);
        check("t5_ready_back", 32'(sample_ready), 32'd1);

        // Reset during STB_B
        clr_stats();
        sample_a = 8'hA5; sample_b = 8'h3C; sample_valid = 1'b1;
        wait_ready(n);
        step();
        sample_valid = 1'b0;
        repeat (9) step();
        check("t6_in_stb_b", 32'({WR, AB, DB}), 32'({1'b0, 1'b1, 8'h3C}));
        #2 Rst = 1'b0;
        #1;
        check("t6_cs", 32'(CS), 32'd1);
        check("t6_wr", 32'(WR), 32'd1);
        check("t6_db", 32'(DB), 32'h00);
        check("t6_ldac", 32'(LDAC), 32'd1);
        check("t6_ready", 32'(sample_ready), 32'd0);
        step();
        Rst = 1'b1;
        step();
        check("t6_post_ready", 32'(sample_ready), 32'd1);
        check("t6_post_busy", 32'(busy), 32'd0);

        clr_stats();
        send(8'h0F, 8'hF0, lat);
        check("t6_after_latency", 32'(lat), 32'd18);
        check_write("t6_after_a", 0, {1'b0, 8'h0F});
        check_write("t6_after_b", 1, {1'b1, 8'hF0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_bus_writer.md
Name: dac_bus_writer

Overview:
- Downstream bus stage between the waveform sample source and the 8-bit dual-channel parallel DAC pins.
- Accepts one A/B sample pair per valid/ready handshake and drives the DAC write sequence: channel A write, then channel B write, then a common LDAC update pulse.
- Services clear requests and holds power-down.
- Owns every DAC control pin: DB, CS, WR, AB, PD, LDAC, CLR.

Parameters:
- SETUP_CYC, 2, Clk cycles with CS low, WR high and DB/AB stable before the WR strobe. Range 1..255.
- WR_CYC, 3, Clk cycles for the WR low pulse. Also the width of the LDAC and CLR low pulses. Range 1..255.
- HOLD_CYC, 2, Clk cycles with CS low, WR high and DB/AB stable after the WR rising edge. Range 1..255.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Rst  in  1  asynchronous, active-low reset.
- sample_a  in  8  channel A code.
- sample_b  in  8  channel B code.
- sample_valid  in  1  sample pair is offered.
- sample_ready  out  1  block accepts a pair this cycle.
- pd_req  in  1  level: 1 requests DAC power-down.
- clr_req  in  1  one-cycle pulse: clear both DAC outputs.
- busy  out  1  a sequence is in progress, or a clear is pending.
- DB  out  8  DAC data bus.
- CS  out  1  chip select, active low.
- WR  out  1  write strobe, active low; the DAC latches on its rising edge.
- AB  out  1  channel select: 0 = A, 1 = B.
- PD  out  1  power-down, active low.
- LDAC  out  1  load DAC outputs, active low.
- CLR  out  1  clear, active low.

Behaviour:
- Reset (Rst=0, asynchronous) forces the following, held until the first Clk edge after release:
  - DB=0x00, CS=1, WR=1, AB=0, PD=1, LDAC=1, CLR=1.
  - sample_ready=0, busy=0, clr_pending=0, state=IDLE, counter=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- PD <= ~pd_req, registered every cycle in every state.
- clr_req sets clr_pending in any state. It is cleared on entry to CLEAR.
- sample_ready = (state==IDLE) & ~clr_pending & ~pd_req. Transfer occurs on sample_valid & sample_ready.
- On transfer, sample_a/sample_b are captured into internal registers. Later input changes have no effect on the sequence.
- State machine; an 8-bit down-counter is loaded on each state entry:
  - IDLE: CS=1, WR=1, LDAC=1, CLR=1; DB/AB hold their last values.
    - clr_pending -> CLEAR. Clear has priority over a valid sample in the same cycle.
    - Otherwise transfer -> SET_A.
  - SET_A (SETUP_CYC): CS=0, WR=1, AB=0, DB=a.
  - STB_A (WR_CYC): WR=0.
  - HLD_A (HOLD_CYC): WR=1.
  - SET_B (SETUP_CYC): CS=0, WR=1, AB=1, DB=b.
  - STB_B (WR_CYC): WR=0.
  - HLD_B (HOLD_CYC): WR=1.
  - LOAD (WR_CYC): CS=1, WR=1, LDAC=0, AB=1, DB=b.
  - LOAD -> IDLE.
  - CLEAR (WR_CYC): CS=1, WR=1, CLR=0. CLEAR -> IDLE.
- CS stays low continuously from SET_A through HLD_B, with no deassertion between channels.
- DB and AB change only on entry to SET_A/SET_B, and only while WR=1.
- Latency, transfer cycle to sample_ready high again: 2*(SETUP_CYC+WR_CYC+HOLD_CYC)+WR_CYC+1 cycles. Defaults give 18; the 17 busy-state cycles are followed by one IDLE cycle with ready=1.
- busy = (state!=IDLE) | clr_pending.
- clr_req mid-sequence: the current A/B/LOAD sequence completes unaltered, then CLEAR runs before any new transfer.
- pd_req asserted mid-sequence: the sequence completes. PD falls one cycle after pd_req rises. No new transfers are accepted while pd_req=1. A pending clear is still serviced.
- Rst asserted mid-sequence: all outputs go to their reset values immediately, CS and WR return high, and the captured pair is discarded.
- Parameter value 0 is illegal. The implementation flags it with an elaboration check.

Test Plan:
- Reset, then one pair A=0x5A, B=0xC3 with default parameters:
  - CS low for exactly 14 cycles.
  - WR low twice, 3 cycles each. At the first WR rise DB=0x5A, AB=0. At the second WR rise DB=0xC3, AB=1.
  - Then LDAC low for 3 cycles with CS=1.
  - sample_ready high again 18 cycles after the transfer.
- sample_valid held high with an incrementing pair 0x00/0x80, 0x01/0x81, ...: back-to-back sequences.
  - Each accepted pair is written exactly once, none is skipped.
  - sample_ready is high for one cycle between sequences.
- clr_req pulsed during STB_A of pair 0x11/0x22:
  - Pair completes including LDAC.
  - Then CLR low 3 cycles. busy stays high throughout.
  - The next pair is accepted only afterward.
- clr_req and sample_valid in the same IDLE cycle: CLEAR runs first. The pair is accepted on the return to IDLE.
- pd_req=1 during SET_B:
  - PD=0 next cycle. The sequence finishes.
  - sample_ready stays 0 while pd_req=1.
  - After pd_req=0: PD=1 next cycle, and ready returns.
- Rst pulsed low mid-STB_B: CS=1, WR=1, DB=0x00 asynchronously. After release, the FSM is in IDLE with ready=1.
